clk_controller: RTL and testbench

CLK_CONTROLLER -- requirements
Module: clk_controller

---
 rtl/clk_ctrl_pkg.sv | 15 +
 rtl/clk_phase_timer.sv | 47 ++++
 rtl/clk_controller.sv | 126 ++++++++++++
 tb/tb_clk_controller.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the processor clock controller: FSM state encoding
// and the reset-time phase lengths.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STEP     = 2'd2,
        ST_STOPPING = 2'd3
    } clk_state_t;

    localparam int CLK_LOW_DEF  = 3;
    localparam int CLK_HIGH_DEF = 3;

endpackage

// File: rtl/clk_phase_timer.sv
// Phase timer: counts clk cycles through a low phase then a high phase and
// flags the last cycle of each; held at the start of a period while disabled.
module clk_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_low_len,
    input  logic [CNT_W-1:0] i_high_len,
    output logic             o_phase,
    output logic             o_low_end,
    output logic             o_high_end
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_low_end;
    logic             w_high_end;

    // Lengths are never below 1, so length-1 is the index of the last cycle.
    assign w_low_end  = i_en && !r_phase && (r_cnt == i_low_len  - CNT_W'(1));
    assign w_high_end = i_en &&  r_phase && (r_cnt == i_high_len - CNT_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_low_end) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_high_end) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_phase    = r_phase;
    assign o_low_end  = w_low_end;
    assign o_high_end = w_high_end;

endmodule

// File: rtl/clk_controller.sv
// Processor clock controller: generates a programmable low/high clock with
// free-run, single-step and period-aligned stop, plus a period counter.
module clk_controller
    import clk_ctrl_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int LOW_DEF  = CLK_LOW_DEF,
    parameter int HIGH_DEF = CLK_HIGH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             run,
    input  logic             halt,
    input  logic             step,
    output logic             clk_out,
    output logic             clk_rise,
    output logic             busy,
    output logic [1:0]       state,
    output logic [15:0]      cycle_count,
    output logic             cfg_err
);

    clk_state_t       r_state;
    clk_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_low_len;
    logic [CNT_W-1:0] r_high_len;
    logic [15:0]      r_cycle_count;
    logic             r_clk_rise;
    logic             r_cfg_err;
    logic             w_idle;
    logic             w_en;
    logic             w_phase;
    logic             w_low_end;
    logic             w_high_end;
    logic             w_cfg_zero;

    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign w_idle     = (r_state == ST_IDLE);
    assign w_en       = !w_idle;
    assign w_cfg_zero = (cfg_low == '0) || (cfg_high == '0);

    clk_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (clk),
        .i_rst_n    (reset_n),
        .i_en       (w_en),
        .i_low_len  (r_low_len),
        .i_high_len (r_high_len),
        .o_phase    (w_phase),
        .o_low_end  (w_low_end),
        .o_high_end (w_high_end)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A stop request landing on the last high cycle skips STOPPING entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (step) begin
                    w_state_nxt = ST_STEP;
                end else if (run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt || !run) begin
                    w_state_nxt = w_high_end ? ST_IDLE : ST_STOPPING;
                end
            end
            ST_STEP, ST_STOPPING: begin
                if (w_high_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Lengths only change in IDLE, so a running period is never reshaped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_low_len  <= CNT_W'(LOW_DEF);
            r_high_len <= CNT_W'(HIGH_DEF);
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && (!w_idle || w_cfg_zero);
            if (cfg_we && w_idle) begin
                r_low_len  <= clamp_len(cfg_low);
                r_high_len <= clamp_len(cfg_high);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_count <= '0;
            r_clk_rise    <= 1'b0;
        end else begin
            r_cycle_count <= r_cycle_count + {15'd0, w_high_end};
            r_clk_rise    <= w_low_end;
        end
    end

    assign clk_out     = w_phase;
    assign clk_rise    = r_clk_rise;
    assign busy        = w_en;
    assign state       = r_state;
    assign cycle_count = r_cycle_count;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_clk_controller.sv
// Bench for clk_controller: cycle model feeding a scoreboard queue, a config
// vector table, and hand-written sequences for halt, reset and wrap corners.
module tb_clk_controller;

    localparam int CNT_W = 4;

    logic             clk      = 1'b0;
    logic             reset_n  = 1'b0;
    logic             cfg_we   = 1'b0;
    logic [CNT_W-1:0] cfg_low  = '0;
    logic [CNT_W-1:0] cfg_high = '0;
    logic             run      = 1'b0;
    logic             halt     = 1'b0;
    logic             step     = 1'b0;
    logic             clk_out;
    logic             clk_rise;
    logic             busy;
    logic [1:0]       state;
    logic [15:0]      cycle_count;
    logic             cfg_err;

    always #5 clk = ~clk;

    clk_controller #(
        .CNT_W    (CNT_W),
        .LOW_DEF  (3),
        .HIGH_DEF (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_low     (cfg_low),
        .cfg_high    (cfg_high),
        .run         (run),
        .halt        (halt),
        .step        (step),
        .clk_out     (clk_out),
        .clk_rise    (clk_rise),
        .busy        (busy),
        .state       (state),
        .cycle_count (cycle_count),
        .cfg_err     (cfg_err)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        ck;
        logic        rise;
        logic        bsy;
        logic        err;
        logic [15:0] cc;
    } obs_t;

    typedef struct {
        logic [3:0] cl;
        logic [3:0] ch;
        logic       sc;
        logic       exp_err;
        int         exp_lo;
        int         exp_hi;
    } vec_t;

    obs_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    int          m_state;
    int          m_pos;
    int          m_low;
    int          m_high;
    logic [15:0] m_cc;
    logic        m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic m_reset();
        m_state = 0;
        m_pos   = 0;
        m_low   = 3;
        m_high  = 3;
        m_cc    = 16'h0000;
        m_err   = 1'b0;
    endtask

    // Model uses a single position-in-period counter (0 .. low+high-1).
    task automatic model_step(input logic rst_lo, input logic we, input logic r, input logic h,
                              input logic s, input logic [3:0] cl, input logic [3:0] ch);
        int   act;
        int   pend;
        int   nst;
        obs_t e;
        if (!rst_lo) begin
            m_reset();
        end else begin
            act   = (m_state != 0) ? 1 : 0;
            pend  = (act != 0 && m_pos == m_low + m_high - 1) ? 1 : 0;
            m_err = we && (act != 0 || cl == '0 || ch == '0);
            m_cc  = m_cc + 16'(pend);
            nst   = m_state;
            case (m_state)
                0: if (s) nst = 2; else if (r) nst = 1;
                1: if (h || !r) nst = (pend != 0) ? 0 : 3;
                default: if (pend != 0) nst = 0;
            endcase
            if (act == 0 && we) begin
                m_low  = (cl == '0) ? 1 : int'(cl);
                m_high = (ch == '0) ? 1 : int'(ch);
            end
            m_pos   = (act != 0 && pend == 0) ? m_pos + 1 : 0;
            m_state = nst;
        end
        e.st   = 2'(m_state);
        e.bsy  = (m_state != 0);
        e.ck   = e.bsy && (m_pos >= m_low);
        e.rise = e.bsy && (m_pos == m_low);
        e.err  = m_err;
        e.cc   = m_cc;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic h, input logic s, input logic we,
                       input logic [3:0] cl, input logic [3:0] ch);
        obs_t a;
        obs_t e;
        @(negedge clk);
        run = r; halt = h; step = s; cfg_we = we; cfg_low = cl; cfg_high = ch;
        @(posedge clk);
        model_step(reset_n, we, r, h, s, cl, ch);
        #1;
        a = {state, clk_out, clk_rise, busy, cfg_err, cycle_count};
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("sb_cycle@%0t", $time), 32'(a), 32'(e));
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic runc();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic drain_to_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 40) begin
            idle();
            n++;
        end
        chk(nm, 32'(state), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   rises;
        int   lo;
        int   hi;
        int   n;

        tbl[0] = '{4'd2,  4'd5, 1'b0, 1'b0, 2,  5};
        tbl[1] = '{4'd0,  4'd3, 1'b0, 1'b1, 1,  3};
        tbl[2] = '{4'd3,  4'd0, 1'b0, 1'b1, 3,  1};
        tbl[3] = '{4'd1,  4'd1, 1'b0, 1'b0, 1,  1};
        tbl[4] = '{4'd15, 4'd2, 1'b0, 1'b0, 15, 2};
        tbl[5] = '{4'd2,  4'd1, 1'b1, 1'b0, 2,  1};
        tbl[6] = '{4'd0,  4'd0, 1'b1, 1'b1, 1,  1};
        tbl[7] = '{4'd3,  4'd3, 1'b0, 1'b0, 3,  3};

        m_reset();

        // reset state, then quiet after release
        idle();
        idle();
        chk("reset_outputs", 32'({state, clk_out, clk_rise, busy, cfg_err, cycle_count}), 32'd0);
        reset_n = 1'b1;
        repeat (3) idle();
        chk("no_activity_after_reset", 32'({state, busy, cycle_count}), 32'd0);

        // free run with default 3/3 lengths
        runc();
        rises = 0;
        for (int i = 0; i < 18; i++) begin
            runc();
            rises += int'(clk_rise);
        end
        chk("run_rise_count", 32'(rises), 32'd3);
        chk("run_cc_after_18", 32'(cycle_count), 32'd3);
        runc();
        drain_to_idle("run_drop_to_idle");

        // halt in the 2nd high cycle completes the high phase
        runc();
        repeat (4) runc();
        chk("halt_pre_second_high", 32'(clk_out), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("halt_stopping_state", 32'(state), 32'd3);
        chk("halt_full_high", 32'(clk_out), 32'd1);
        idle();
        chk("halt_idle_state", 32'(state), 32'd0);
        chk("halt_idle_clk", 32'(clk_out), 32'd0);

        // halt landing on the last high cycle goes straight to IDLE
        runc();
        repeat (5) runc();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("halt_at_end_idle", 32'(state), 32'd0);
        idle();

        // config vector table: write (or write+step), then one stepped period
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, tbl[k].sc, 1'b1, tbl[k].cl, tbl[k].ch);
            chk($sformatf("tbl%0d_cfg_err", k), 32'(cfg_err), 32'(tbl[k].exp_err));
            if (!tbl[k].sc) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
            chk($sformatf("tbl%0d_step_state", k), 32'(state), 32'd2);
            lo = 0;
            hi = 0;
            n  = 0;
            while (busy && n < 40) begin
                if (clk_out) hi++;
                else lo++;
                n++;
                idle();
            end
            chk($sformatf("tbl%0d_low_len", k), 32'(lo), 32'(tbl[k].exp_lo));
            chk($sformatf("tbl%0d_high_len", k), 32'(hi), 32'(tbl[k].exp_hi));
            chk($sformatf("tbl%0d_back_idle", k), 32'(state), 32'd0);
        end

        // config write and step while running are rejected/ignored
        runc();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1);
        chk("cfg_in_run_err", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, (i % 4 == 1), 1'b0, 4'd0, 4'd0);
        chk("step_ignored_in_run", 32'(state), 32'd1);
        drain_to_idle("cfg_run_stop_idle");

        // run and step together start a single step
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk("run_and_step_is_step", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("halt_ignored_in_step", 32'(state), 32'd2);
        drain_to_idle("step_done_idle");

        // asynchronous reset in the middle of a high phase
        runc();
        repeat (4) runc();
        chk("pre_reset_high", 32'(clk_out), 32'd1);
        #1 reset_n = 1'b0;
        m_reset();
        #1;
        chk("reset_async_clk", 32'(clk_out), 32'd0);
        chk("reset_async_all", 32'({state, clk_out, clk_rise, busy, cfg_err, cycle_count}), 32'd0);
        idle();
        idle();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b0, (i % 2 == 0), 1'b0, 1'b0, 4'd0, 4'd0);
        chk("post_reset_quiet", 32'({state, busy, clk_out}), 32'd0);
        runc();
        chk("post_reset_run", 32'(state), 32'd1);
        drain_to_idle("post_reset_stop");

        // cycle_count wrap at 1/1 lengths
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1);
        force dut.r_cycle_count = 16'hFFFD;
        m_cc = 16'hFFFD;
        idle();
        release dut.r_cycle_count;
        runc();
        runc();
        runc();
        chk("wrap_fffe", 32'(cycle_count), 32'h0000FFFE);
        runc();
        runc();
        chk("wrap_ffff", 32'(cycle_count), 32'h0000FFFF);
        runc();
        runc();
        chk("wrap_zero", 32'(cycle_count), 32'h00000000);
        drain_to_idle("wrap_stop_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
